// File: rtl/apb_slave_mem.sv
// APB slave with a small word-addressed memory.
// A transfer is captured in its setup cycle, optionally held for WAIT cycles,
// then completed in a single ACCESS cycle in which pready is high.
// Addresses at or beyond DEPTH complete with pslverr; writes to them are
// dropped and reads from them return zero.
module apb_slave_mem #(
  parameter int DW    = 8,
  parameter int AW    = 9,
  parameter int DEPTH = 64,
  parameter int WAIT  = 0
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [DW-1:0] pwdata,
  output logic [DW-1:0] prdata,
  output logic          pready,
  output logic          pslverr
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic [AW-1:0] addr_q, addr_nxt;
  logic          wr_q, wr_nxt;
  logic [DW-1:0] wdata_q, wdata_nxt;
  logic          setup, capture, mem_we;
  logic [DW-1:0] mem [DEPTH];

  // True when the word address maps onto real storage.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return 64'(a) < 64'(DEPTH);
  endfunction

  // Next-state, request capture and write-enable decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    wr_nxt    = wr_q;
    wdata_nxt = wdata_q;
    setup     = psel && !penable;
    capture   = 1'b0;
    mem_we    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (setup) capture = 1'b1;
      end
      S_WAIT: begin
        if (!psel) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // The write lands only if the master is still in a valid access phase.
        mem_we = psel && penable && wr_q && addr_ok(addr_q);
        if (setup) capture = 1'b1;
        else       state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A new request is latched here and held unchanged until it completes.
    if (capture) begin
      addr_nxt  = paddr;
      wr_nxt    = pwrite;
      wdata_nxt = pwdata;
      if (WAIT == 0) begin
        state_nxt = S_ACCESS;
      end else begin
        state_nxt = S_WAIT;
        cnt_nxt   = 4'(WAIT);
      end
    end
  end

  // State, wait counter, captured request and registered response outputs.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      addr_q  <= addr_nxt;
      wr_q    <= wr_nxt;
      wdata_q <= wdata_nxt;
      // Every move into ACCESS is the start of a fresh completion cycle.
      pready  <= (state_nxt == S_ACCESS);
      pslverr <= (state_nxt == S_ACCESS) && !addr_ok(addr_nxt);
      if ((state_nxt == S_ACCESS) && !wr_nxt) begin
        prdata <= addr_ok(addr_nxt) ? mem[addr_nxt[IW-1:0]] : '0;
      end
    end
  end

  // Storage array, cleared as a whole by reset.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (mem_we) begin
      mem[addr_q[IW-1:0]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: a zero-wait and a three-wait instance share one
// APB stimulus stream and are both compared every cycle against a
// transfer-level reference model, plus directed literal checks.
module tb_apb_slave_mem;

  localparam int DW    = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 64;
  localparam int WAITV [2] = '{0, 3};

  logic           pclk = 1'b0;
  logic           preset;
  logic           psel, penable, pwrite;
  logic [AW-1:0]  paddr;
  logic [DW-1:0]  pwdata;
  logic [1:0]          rdy, err;
  logic [1:0][DW-1:0]  rd;

  int n_chk = 0;
  int n_err = 0;

  always #5 pclk = ~pclk;

  apb_slave_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT(0)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(rd[0]), .pready(rdy[0]), .pslverr(err[0])
  );

  apb_slave_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT(3)) dut3 (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(rd[1]), .pready(rdy[1]), .pslverr(err[1])
  );

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // ---------------- reference model (one per instance) ----------------
  bit          m_busy [2];  // transfer captured, waiting out its wait cycles
  bit          m_done [2];  // current cycle is the completion cycle
  int          m_left [2];
  int          t_addr [2];
  bit          t_wr   [2];
  logic [7:0]  t_data [2];
  logic [7:0]  m_mem  [2][DEPTH];
  logic        e_rdy  [2];
  logic        e_err  [2];
  logic [7:0]  e_rd   [2];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (preset) begin
        m_busy[k] = 0; m_done[k] = 0; m_left[k] = 0;
        e_rdy[k] = 0; e_err[k] = 0; e_rd[k] = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[k][i] = 0;
      end else begin
        bit start;
        start = 0;
        if (m_done[k]) begin
          if (psel && penable && t_wr[k] && t_addr[k] < DEPTH)
            m_mem[k][t_addr[k]] = t_data[k];
          m_done[k] = 0;
          start = psel && !penable;
        end else if (m_busy[k]) begin
          if (!psel) begin
            m_busy[k] = 0;
          end else begin
            m_left[k]--;
            if (m_left[k] == 0) begin m_busy[k] = 0; m_done[k] = 1; end
          end
        end else begin
          start = psel && !penable;
        end
        if (start) begin
          t_addr[k] = int'(paddr);
          t_wr[k]   = pwrite;
          t_data[k] = pwdata;
          if (WAITV[k] == 0) m_done[k] = 1;
          else begin m_busy[k] = 1; m_left[k] = WAITV[k]; end
        end
        e_rdy[k] = m_done[k];
        e_err[k] = m_done[k] && (t_addr[k] >= DEPTH);
        if (m_done[k] && !t_wr[k])
          e_rd[k] = (t_addr[k] < DEPTH) ? m_mem[k][t_addr[k]] : 8'h00;
      end
    end
  endtask

  initial forever begin
    @(posedge pclk or posedge preset);
    model_step();
  end

  // Every-cycle comparison of both instances against the model.
  initial forever begin
    @(negedge pclk);
    for (int k = 0; k < 2; k++) begin
      check("model_pready",  k, 32'(rdy[k]), 32'(e_rdy[k]));
      check("model_pslverr", k, 32'(err[k]), 32'(e_err[k]));
      check("model_prdata",  k, 32'(rd[k]),  32'(e_rd[k]));
    end
  end

  // One APB transfer paced for instance k; called and returning at posedge+2.
  task automatic xfer(input int k, input bit wr, input int a, input int d,
                      output int lat, output logic [7:0] rdv, output logic ev);
    psel = 1; penable = 0; pwrite = wr; paddr = 9'(a); pwdata = 8'(d);
    @(posedge pclk); #2;
    penable = 1;
    lat = 1;
    while (1) begin
      @(negedge pclk);
      if (rdy[k]) break;
      lat++;
      if (lat > 20) begin
        check("pready_timeout", k, 32'(rdy[k]), 32'd1);
        break;
      end
    end
    rdv = rd[k];
    ev  = err[k];
    @(posedge pclk); #2;
    psel = 0; penable = 0;
  endtask

  initial begin
    int lat;
    logic [7:0] rv;
    logic ev;
    logic seen;
    preset = 1; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    repeat (2) @(posedge pclk);
    #2 preset = 0;
    @(negedge pclk);
    for (int k = 0; k < 2; k++) begin
      check("reset_pready",  k, 32'(rdy[k]), 32'd0);
      check("reset_pslverr", k, 32'(err[k]), 32'd0);
      check("reset_prdata",  k, 32'(rd[k]),  32'd0);
    end
    @(posedge pclk); #2;

    // Zero-wait write then read back.
    xfer(0, 1, 3, 8'hA5, lat, rv, ev);
    check("w0_latency", 0, 32'(lat), 32'd1);
    xfer(0, 0, 3, 0, lat, rv, ev);
    check("r0_data", 0, 32'(rv), 32'hA5);
    check("r0_err",  0, 32'(ev), 32'd0);

    // Three-wait read of an unwritten word.
    xfer(1, 0, 10, 0, lat, rv, ev);
    check("w3_latency", 1, 32'(lat), 32'd4);
    check("w3_data",    1, 32'(rv),  32'h00);
    check("w3_err",     1, 32'(ev),  32'd0);

    // Out-of-range address on both instances.
    for (int k = 0; k < 2; k++) begin
      xfer(k, 1, 100, 8'hFF, lat, rv, ev);
      check("oor_wr_err", k, 32'(ev), 32'd1);
      xfer(k, 0, 100, 0, lat, rv, ev);
      check("oor_rd_err",  k, 32'(ev), 32'd1);
      check("oor_rd_data", k, 32'(rv), 32'h00);
    end

    // Back-to-back write then read of the same word.
    for (int k = 0; k < 2; k++) begin
      xfer(k, 1, 5, 8'h3C, lat, rv, ev);
      xfer(k, 0, 5, 0, lat, rv, ev);
      check("b2b_data", k, 32'(rv), 32'h3C);
    end

    // Write to addr 7 abandoned during the wait cycles of the 3-wait instance.
    psel = 1; penable = 0; pwrite = 1; paddr = 9'd7; pwdata = 8'h77;
    @(posedge pclk); #2 penable = 1;
    @(posedge pclk); #2 psel = 0; penable = 0;
    seen = 0;
    repeat (5) begin
      @(negedge pclk);
      seen = seen | rdy[1];
    end
    check("abort_no_pready", 1, 32'(seen), 32'd0);
    @(posedge pclk); #2;
    xfer(1, 0, 7, 0, lat, rv, ev);
    check("abort_no_write", 1, 32'(rv), 32'h00);

    // Reset pulsed between edges while a read is in its completion cycle.
    xfer(0, 1, 2, 8'h11, lat, rv, ev);
    psel = 1; penable = 0; pwrite = 0; paddr = 9'd2;
    @(posedge pclk); #2 penable = 1;
    @(negedge pclk);
    check("pre_rst_pready", 0, 32'(rdy[0]), 32'd1);
    check("pre_rst_prdata", 0, 32'(rd[0]),  32'h11);
    #3 preset = 1;
    #1;
    check("async_rst_pready", 0, 32'(rdy[0]), 32'd0);
    check("async_rst_prdata", 0, 32'(rd[0]),  32'h00);
    @(posedge pclk); #2;
    preset = 0; psel = 0; penable = 0;
    @(posedge pclk); #2;
    xfer(0, 0, 2, 0, lat, rv, ev);
    check("rst_cleared_a2", 0, 32'(rv), 32'h00);
    xfer(0, 0, 3, 0, lat, rv, ev);
    check("rst_cleared_a3", 0, 32'(rv), 32'h00);

    // Randomized traffic: well-formed transfers, raw bus noise, rare resets.
    for (int it = 0; it < 800; it++) begin
      int r;
      int a;
      r = $urandom_range(0, 99);
      a = ($urandom_range(0, 9) == 0) ? $urandom_range(64, 511) : $urandom_range(0, 15);
      if (r < 35) begin
        xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), a, $urandom_range(0, 255),
             lat, rv, ev);
      end else if (r < 98) begin
        psel    = ($urandom_range(0, 4) != 0);
        penable = 1'($urandom_range(0, 1));
        pwrite  = 1'($urandom_range(0, 1));
        paddr   = 9'(a);
        pwdata  = 8'($urandom_range(0, 255));
        @(posedge pclk); #2;
      end else begin
        preset = 1;
        @(posedge pclk); #2;
        preset = 0;
      end
    end

    psel = 0; penable = 0;
    repeat (4) @(posedge pclk);
    @(negedge pclk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/apb_slave_mem.md
APB_SLAVE_MEM -- requirements
Module: apb_slave_mem

Interface
REQ-001 SHALL have parameter DW, default 8: data width in bits.
REQ-002 SHALL have parameter AW, default 9: APB address width in bits.
REQ-003 SHALL have parameter DEPTH, default 64: number of storage words, at most 2^AW.
REQ-004 SHALL have parameter WAIT, default 0, range 0..15: wait cycles inserted before PREADY.
REQ-005 SHALL have port pclk, input, 1 bit: the only clock; all state updates on rising edge.
REQ-006 SHALL have port preset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port psel, input, 1 bit: slave select from the APB master.
REQ-008 SHALL have port penable, input, 1 bit: access-phase indicator.
REQ-009 SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-010 SHALL have port paddr, input, AW bits: word address.
REQ-011 SHALL have port pwdata, input, DW bits: write data.
REQ-012 SHALL have port prdata, output, DW bits: registered read data.
REQ-013 SHALL have port pready, output, 1 bit: transfer complete, registered.
REQ-014 SHALL have port pslverr, output, 1 bit: transfer error, qualified by pready.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACCESS.
REQ-016 IDLE, psel=1 & penable=0: SHALL capture paddr, pwrite and pwdata at that edge, then go to WAIT with counter=WAIT, or to ACCESS directly if WAIT=0.
REQ-017 IDLE, psel=0 or penable=1 (protocol violation): SHALL remain in IDLE with no side effects.
REQ-018 WAIT: SHALL decrement the counter each cycle; go to ACCESS on the edge where counter reaches 1; pready=0 throughout.
REQ-019 WAIT or ACCESS, psel=0 (aborted transfer): SHALL return to IDLE, with no memory write and no pready pulse.
REQ-020 pready SHALL be 1 exactly during ACCESS cycles; a zero-wait transfer therefore spans 2 cycles, and an N-wait transfer spans 2+N cycles.
REQ-021 Write SHALL commit mem[addr] <= captured pwdata on the ACCESS-exit edge, only when psel=1, penable=1 and addr<DEPTH.
REQ-022 Read: prdata SHALL be loaded from mem[captured addr] on the edge entering ACCESS and SHALL hold otherwise.
REQ-023 Write in the transfer immediately preceding a read of the same address: the read SHALL return the new data.
REQ-024 Captured addr >= DEPTH: pslverr SHALL be 1 during ACCESS; writes are dropped; reads return prdata=0.
REQ-025 pslverr SHALL be 0 whenever pready=0.
REQ-026 ACCESS exit, psel=1 & penable=0 (back-to-back transfer): SHALL capture the new request and go to WAIT/ACCESS without passing through IDLE.
REQ-027 ACCESS exit, any other input: SHALL go to IDLE.
REQ-028 Inputs changing during WAIT SHALL NOT alter the captured address, data or direction.

Reset
REQ-029 preset=1 SHALL immediately force state=IDLE, counter=0, pready=0, pslverr=0, prdata=0 and all memory words=0, regardless of clock.
REQ-030 Reset asserted mid-transfer SHALL abort that transfer with no write; the first transfer after deassertion SHALL behave as from IDLE.

Verification
REQ-031 WAIT=0: write 0xA5 to addr 3 -> pready high in cycle 2; then read addr 3 -> prdata=0xA5, pslverr=0.
REQ-032 WAIT=3: read addr 10 -> pready low for exactly 3 cycles after setup, then high 1 cycle with prdata=0x00.
REQ-033 Access addr 100 (DEPTH=64): write 0xFF then read -> pslverr=1 with pready both times, prdata=0x00, mem unchanged.
REQ-034 Back-to-back write addr 5=0x3C then read addr 5 with no idle cycle -> read returns 0x3C, no IDLE state between the transfers.
REQ-035 psel dropped during WAIT of a write 0x77 to addr 7 -> no pready pulse; subsequent read addr 7 returns 0x00.
REQ-036 preset pulsed between clock edges during ACCESS -> pready=0 and prdata=0 immediately; earlier writes cleared to 0.
